fpu_wb_arbiter: RTL

- Collects results from the FPU execution units and serializes them onto the single write port of the FPU register file, one write per cycle, with registered outputs.
- A small FIFO absorbs fixed-latency pipelined results that lose arbitration or arrive while writeback is stalled.
- Per-result IEEE exception flags accompany each write so the FCSR update logic can merge them.
- Exports a pending-write mask for hazard detection.

---
 rtl/fpu_wb_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/fpu_wb_arbiter.sv
// fpu_wb_arbiter: serializes FPU pipelined and iterative results onto the single register-file write port
module fpu_wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int FMT_W  = 2,
  parameter int ALMOST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wb_stall,
  input  logic             p_valid,
  input  logic [4:0]       p_addr,
  input  logic [31:0]      p_val,
  input  logic [FMT_W-1:0] p_fmt,
  input  logic [4:0]       p_flags,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [4:0]       i_addr,
  input  logic [31:0]      i_val,
  input  logic [FMT_W-1:0] i_fmt,
  input  logic [4:0]       i_flags,
  output logic             wr_we,
  output logic [4:0]       wr_waddr,
  output logic [31:0]      wr_val,
  output logic [FMT_W-1:0] wr_fmt,
  output logic [4:0]       wr_flags,
  output logic             stall_req,
  output logic [31:0]      pending,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]        count, count_n;
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [4:0]         q_addr  [DEPTH];
  logic [31:0]        q_val   [DEPTH];
  logic [FMT_W-1:0]   q_fmt   [DEPTH];
  logic [4:0]         q_flags [DEPTH];
  logic [DEPTH-1:0]   q_vld, vld_n;
  logic [31:0]        pend_n;
  logic               empty, full, pop, byp, push, drop;
  assign empty     = count == '0;
  assign full      = count == (AW+1)'(DEPTH);
  assign pop       = ~wb_stall & ~flush & ~empty;
  assign byp       = ~wb_stall & ~flush & empty & p_valid;
  assign push      = p_valid & ~flush & (~empty | wb_stall) & (~full | pop);
  assign drop      = p_valid & ~flush & full & ~pop;
  assign i_ready   = i_valid & ~wb_stall & ~flush & empty & ~p_valid & rst;
  assign count_n   = flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  assign stall_req = (DEPTH - int'(count)) <= ALMOST;
  // next-cycle slot occupancy and the pending mask it implies
  always_comb begin
    vld_n = flush ? '0 : q_vld;
    if (pop) vld_n[rd_ptr] = 1'b0;
    if (push) vld_n[wr_ptr] = 1'b1;
    pend_n = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_n[i]) pend_n |= 32'd1 << ((push && AW'(i) == wr_ptr) ? p_addr : q_addr[i]);
  end
  // FIFO payload storage, written only on push
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= p_addr;
      q_val[wr_ptr]   <= p_val;
      q_fmt[wr_ptr]   <= p_fmt;
      q_flags[wr_ptr] <= p_flags;
    end
  end
  // FIFO control state, sticky overflow and registered pending mask
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_vld    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_n;
      rd_ptr   <= flush ? '0 : rd_ptr + AW'(pop);
      wr_ptr   <= flush ? '0 : wr_ptr + AW'(push);
      q_vld    <= vld_n;
      pending  <= pend_n;
      overflow <= overflow | drop;
    end
  end
  // registered write port: FIFO head, then bypassed pipelined result, then iterative result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_we    <= 1'b0;
      wr_waddr <= '0;
      wr_val   <= '0;
      wr_fmt   <= '0;
      wr_flags <= '0;
    end else begin
      wr_we <= pop | byp | i_ready;
      if (pop | byp | i_ready) begin
        wr_waddr <= pop ? q_addr[rd_ptr]  : byp ? p_addr  : i_addr;
        wr_val   <= pop ? q_val[rd_ptr]   : byp ? p_val   : i_val;
        wr_fmt   <= pop ? q_fmt[rd_ptr]   : byp ? p_fmt   : i_fmt;
        wr_flags <= pop ? q_flags[rd_ptr] : byp ? p_flags : i_flags;
      end
    end
  end
endmodule
